des_mmio_ctrl: RTL and testbench
================================

Name: des_mmio_ctrl

Overview:
- Memory-mapped control stage between the MIPS pipeline memory port (M stage) and an iterative, multi-cycle DES core.
- Decodes M-stage stores and loads. Holds the 64-bit key and data registers, sequences start/done with the core, captures the 64-bit result, and exposes status.
- Muxes peripheral reads against dmem reads. Non-peripheral addresses pass through to dmem.

Parameters:
- BASE_ADDR, 32'h0000_FF00, base of the 32-byte peripheral window (aligned to 32 bytes).
- TIMEOUT_CYCLES, 64, watchdog limit in clocks. Used only with DES_TIMEOUT_EN.
- CNT_W, 7, watchdog counter width. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- memwrite  in  1  store in M stage
- addr  in  32  M-stage address (aluout)
- writedata  in  32  M-stage store data
- dmem_rdata  in  32  combinational dmem read data
- dmem_we  out  1  dmem write enable: memwrite AND address outside window
- readdata  out  32  load data returned to pipeline
- des_key  out  64  {UK,LK}
- des_data  out  64  {UD,LD}
- des_encdec  out  1  1 = encrypt, 0 = decrypt
- des_start  out  1  one-cycle start pulse to core
- des_done  in  1  one-cycle completion pulse from core
- des_result  in  64  core result, valid in the des_done cycle
- irq  out  1  level: DONE AND IRQ_EN

Behaviour:
- Reset (async, reset_n=0): every register 0, FSM IDLE, des_start=0, irq=0. Reset asserted mid-operation aborts the run; a later des_done is ignored because the FSM is IDLE.
- Window hit is defined as addr[31:5]==BASE_ADDR[31:5]; offset is addr[4:2].
- Word offsets:
  - 0 UK, 1 LK, 2 UD, 3 LD (RW).
  - 4 CTRL: bit0 START (write-1 pulse, reads 0), bit1 ENCDEC, bit2 IRQ_EN.
  - 5 STATUS: bit0 BUSY, bit1 DONE (sticky, write-1-clear), bit2 OVERRUN (sticky, W1C), bit3 TIMEOUT (sticky, W1C).
  - 6 RES_HI = result[63:32], 7 RES_LO = result[31:0] (RO; writes ignored).
- Reads are combinational, same cycle as addr. Returns the selected register on a window hit, else dmem_rdata. Unused bits read 0.
- Writes take effect on the clk rising edge when memwrite=1 and the window is hit.
- FSM states:
  - IDLE: a write of CTRL with bit0=1 latches ENCDEC/IRQ_EN, clears DONE, and goes to START.
  - START: des_start=1 for exactly one cycle, then go to WAIT.
  - WAIT: on des_done, capture des_result into RES, set DONE, go to IDLE.
- BUSY=1 in START and WAIT.
- Latency: the START write at edge N gives des_start high in cycle N+1. A des_done sampled at edge M gives BUSY=0 and DONE=1 visible after edge M.
- While BUSY:
  - Writes to UK/LK/UD/LD/CTRL are dropped and set OVERRUN.
  - STATUS W1C writes still apply.
  - des_key and des_data stay stable for the whole run.
- des_done outside WAIT is ignored.
- Same-cycle DONE set and DONE W1C: set wins. The same rule applies to OVERRUN.
- CTRL write with bit0=0 in IDLE updates ENCDEC/IRQ_EN only.

Optional Feature:
- Macro: DES_TIMEOUT_EN.
- Defined:
  - Watchdog counter clears on entry to START and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES with no des_done, the FSM goes to IDLE, sets TIMEOUT, leaves DONE=0 and leaves RES unchanged.
  - des_done in the same cycle as the timeout counts as completion.
- Undefined: WAIT is held indefinitely, no counter logic exists, and STATUS bit3 reads 0.

Decomposition:
- Package des_mmio_pkg:
  - Word-offset localparams (OFF_UK..OFF_RESLO).
  - STATUS/CTRL bit indices.
  - State encoding (IDLE=2'd0, START=2'd1, WAIT=2'd2).
- One sub-module, des_mmio_decode (combinational): addr/memwrite in; hit, offset, per-register write strobes and dmem_we out.
- FSM, registers and read mux stay in des_mmio_ctrl.

Test Plan:
- Register access: store 32'h0123_4567 to BASE+0 and 32'h89AB_CDEF to BASE+4 -> des_key=64'h0123456789ABCDEF, and loads from BASE+0/4 return the same words.
- Start/done: write CTRL=32'h3 -> des_start high exactly 1 cycle, STATUS reads 32'h1. Core pulses des_done 16 cycles later with 64'h85E813540F0AB405 -> STATUS=32'h2, RES_HI=32'h85E81354, RES_LO=32'h0F0AB405.
- Overrun: while BUSY, store 32'hFFFF_FFFF to BASE+8 -> UD unchanged, STATUS bit2=1. Writing STATUS=32'h4 clears it.
- Pass-through: store to address 32'h0000_0040 -> dmem_we=1, no peripheral change. A load returns dmem_rdata. A store to BASE+4 gives dmem_we=0.
- IRQ and W1C race: with IRQ_EN=1, completion -> irq=1. A W1C of DONE in the same cycle as a new des_done leaves DONE=1.
- Reset and timeout: reset_n low during WAIT -> all registers 0, des_start 0, and a late des_done is ignored. With DES_TIMEOUT_EN, no des_done for 64 cycles -> STATUS=32'h8, BUSY=0.

Source files
------------

// File: rtl/des_mmio_pkg.sv
// Shared definitions for the DES memory-mapped control stage: register map,
// CTRL/STATUS bit positions, FSM encoding and the write-strobe bundle.
package des_mmio_pkg;

  localparam logic [2:0] OFF_UK    = 3'd0;
  localparam logic [2:0] OFF_LK    = 3'd1;
  localparam logic [2:0] OFF_UD    = 3'd2;
  localparam logic [2:0] OFF_LD    = 3'd3;
  localparam logic [2:0] OFF_CTRL  = 3'd4;
  localparam logic [2:0] OFF_STAT  = 3'd5;
  localparam logic [2:0] OFF_RESHI = 3'd6;
  localparam logic [2:0] OFF_RESLO = 3'd7;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ENCDEC = 1;
  localparam int CTRL_IRQEN  = 2;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_OVERRUN = 2;
  localparam int ST_TIMEOUT = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // One strobe per writable register; RES_HI/RES_LO are read-only.
  typedef struct packed {
    logic uk;
    logic lk;
    logic ud;
    logic ld;
    logic ctrl;
    logic status;
  } wr_strobe_t;

endpackage

// File: rtl/des_mmio_decode.sv
// Combinational address decode for the 32-byte DES peripheral window:
// window hit, word offset, per-register write strobes and dmem write enable.
module des_mmio_decode
  import des_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_FF00
) (
  input  logic [31:0] addr,
  input  logic        memwrite,
  output logic        hit,
  output logic [2:0]  offset,
  output wr_strobe_t  we,
  output logic        dmem_we
);

  logic wr_hit;
  // Byte-lane bits do not take part in word decode.
  logic unused_byte_bits;

  assign unused_byte_bits = ^addr[1:0];
  assign hit     = (addr[31:5] == BASE_ADDR[31:5]);
  assign offset  = addr[4:2];
  assign wr_hit  = memwrite & hit;
  assign dmem_we = memwrite & ~hit;

  always_comb begin
    we        = '0;
    we.uk     = wr_hit && (offset == OFF_UK);
    we.lk     = wr_hit && (offset == OFF_LK);
    we.ud     = wr_hit && (offset == OFF_UD);
    we.ld     = wr_hit && (offset == OFF_LD);
    we.ctrl   = wr_hit && (offset == OFF_CTRL);
    we.status = wr_hit && (offset == OFF_STAT);
  end

endmodule

// File: rtl/des_mmio_ctrl.sv
// MMIO control stage between the MIPS M-stage memory port and an iterative DES
// core. Optional watchdog enabled by defining DES_TIMEOUT_EN.
module des_mmio_ctrl
  import des_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_FF00,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter int          CNT_W          = 7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_we,
  output logic [31:0] readdata,
  output logic [63:0] des_key,
  output logic [63:0] des_data,
  output logic        des_encdec,
  output logic        des_start,
  input  logic        des_done,
  input  logic [63:0] des_result,
  output logic        irq
);

  // Handshake: des_start is a single-cycle request; the core answers later
  // with a single-cycle des_done carrying des_result. No back-pressure.

  logic        hit;
  logic [2:0]  offset;
  wr_strobe_t  we;

  state_t      state, state_next;
  logic        busy;
  logic        start_go;
  logic        set_done;
  logic        set_overrun;
  logic        timeout_bit;

  logic [31:0] uk, lk, ud, ld;
  logic        encdec, irq_en;
  logic        done, overrun;
  logic [63:0] res;

  des_mmio_decode #(.BASE_ADDR(BASE_ADDR)) u_decode (
    .addr     (addr),
    .memwrite (memwrite),
    .hit      (hit),
    .offset   (offset),
    .we       (we),
    .dmem_we  (dmem_we)
  );

`ifdef DES_TIMEOUT_EN
  logic [CNT_W-1:0] wdog;
  logic             set_timeout;
  logic             wdog_expired;

  assign wdog_expired = (wdog == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_go   = 1'b0;
    set_done   = 1'b0;
    des_start  = 1'b0;
`ifdef DES_TIMEOUT_EN
    set_timeout = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (we.ctrl && writedata[CTRL_START]) begin
          start_go   = 1'b1;
          state_next = S_START;
        end
      end
      S_START: begin
        des_start  = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        // A completion in the expiry cycle still counts as completion.
        if (des_done) begin
          set_done   = 1'b1;
          state_next = S_IDLE;
        end
`ifdef DES_TIMEOUT_EN
        else if (wdog_expired) begin
          set_timeout = 1'b1;
          state_next  = S_IDLE;
        end
`endif
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Register-file writes are locked out for the whole run so the core sees
  // stable operands; a blocked write is flagged as OVERRUN instead.
  assign set_overrun = busy & (we.uk | we.lk | we.ud | we.ld | we.ctrl);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uk      <= '0;
      lk      <= '0;
      ud      <= '0;
      ld      <= '0;
      encdec  <= 1'b0;
      irq_en  <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
      res     <= '0;
    end else begin
      if (!busy && we.uk) uk <= writedata;
      if (!busy && we.lk) lk <= writedata;
      if (!busy && we.ud) ud <= writedata;
      if (!busy && we.ld) ld <= writedata;
      if (!busy && we.ctrl) begin
        encdec <= writedata[CTRL_ENCDEC];
        irq_en <= writedata[CTRL_IRQEN];
      end

      // Set beats write-1-clear when both land in the same cycle.
      if (set_done)                              done <= 1'b1;
      else if (start_go)                         done <= 1'b0;
      else if (we.status && writedata[ST_DONE])  done <= 1'b0;

      if (set_overrun)                              overrun <= 1'b1;
      else if (we.status && writedata[ST_OVERRUN])  overrun <= 1'b0;

      if (set_done) res <= des_result;
    end
  end

`ifdef DES_TIMEOUT_EN
  logic timeout_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (start_go)             wdog <= '0;
      else if (state == S_WAIT) wdog <= wdog + 1'b1;

      if (set_timeout)                              timeout_q <= 1'b1;
      else if (we.status && writedata[ST_TIMEOUT])  timeout_q <= 1'b0;
    end
  end

  assign timeout_bit = timeout_q;
`else
  assign timeout_bit = 1'b0;
`endif

  assign des_key    = {uk, lk};
  assign des_data   = {ud, ld};
  assign des_encdec = encdec;
  assign irq        = done & irq_en;

  always_comb begin
    readdata = dmem_rdata;
    if (hit) begin
      case (offset)
        OFF_UK:    readdata = uk;
        OFF_LK:    readdata = lk;
        OFF_UD:    readdata = ud;
        OFF_LD:    readdata = ld;
        OFF_CTRL:  readdata = {29'd0, irq_en, encdec, 1'b0};
        OFF_STAT:  readdata = {28'd0, timeout_bit, overrun, done, busy};
        OFF_RESHI: readdata = res[63:32];
        OFF_RESLO: readdata = res[31:0];
        default:   readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_des_mmio_ctrl.sv
// Self-checking bench for des_mmio_ctrl: directed stimulus pushes expected
// values into a scoreboard queue that a negedge monitor drains and compares.
module tb_des_mmio_ctrl;

  localparam logic [31:0] BASE = 32'h0000_FF00;
  localparam logic [31:0] A_UK    = BASE + 32'd0;
  localparam logic [31:0] A_LK    = BASE + 32'd4;
  localparam logic [31:0] A_UD    = BASE + 32'd8;
  localparam logic [31:0] A_LD    = BASE + 32'd12;
  localparam logic [31:0] A_CTRL  = BASE + 32'd16;
  localparam logic [31:0] A_STAT  = BASE + 32'd20;
  localparam logic [31:0] A_RESHI = BASE + 32'd24;
  localparam logic [31:0] A_RESLO = BASE + 32'd28;
  localparam logic [31:0] DMEM_WORD = 32'hCAFE_F00D;

  localparam int SEL_RD     = 0;
  localparam int SEL_KEY    = 1;
  localparam int SEL_DATA   = 2;
  localparam int SEL_START  = 3;
  localparam int SEL_IRQ    = 4;
  localparam int SEL_DMEMWE = 5;
  localparam int SEL_ENCDEC = 6;

  logic        clk;
  logic        reset_n;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] dmem_rdata;
  logic        dmem_we;
  logic [31:0] readdata;
  logic [63:0] des_key;
  logic [63:0] des_data;
  logic        des_encdec;
  logic        des_start;
  logic        des_done;
  logic [63:0] des_result;
  logic        irq;

  logic [63:0] exp_q[$];
  int          sel_q[$];
  string       name_q[$];
  int          checks;
  int          passed;
  int          errors;

  des_mmio_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .memwrite   (memwrite),
    .addr       (addr),
    .writedata  (writedata),
    .dmem_rdata (dmem_rdata),
    .dmem_we    (dmem_we),
    .readdata   (readdata),
    .des_key    (des_key),
    .des_data   (des_data),
    .des_encdec (des_encdec),
    .des_start  (des_start),
    .des_done   (des_done),
    .des_result (des_result),
    .irq        (irq)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", checks, passed);
    $fatal(1, "time limit");
  end

  // Driver tasks: each step starts just after a rising edge and holds for one
  // cycle; a store is committed at the rising edge that ends its step.
  task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d,
                      input logic dn, input logic [63:0] r);
    @(posedge clk);
    #1;
    memwrite   = mw;
    addr       = a;
    writedata  = d;
    des_done   = dn;
    des_result = r;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(1'b1, a, d, 1'b0, 64'd0);
  endtask

  task automatic idle();
    step(1'b0, 32'h0000_0100, 32'd0, 1'b0, 64'd0);
  endtask

  task automatic expect_sig(input int sel, input logic [63:0] v, input string nm);
    exp_q.push_back(v);
    sel_q.push_back(sel);
    name_q.push_back(nm);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] v, input string nm);
    step(1'b0, a, 32'd0, 1'b0, 64'd0);
    expect_sig(SEL_RD, {32'd0, v}, nm);
  endtask

  // Scoreboard monitor
  function automatic logic [63:0] observe(input int sel);
    case (sel)
      SEL_RD:     return {32'd0, readdata};
      SEL_KEY:    return des_key;
      SEL_DATA:   return des_data;
      SEL_START:  return {63'd0, des_start};
      SEL_IRQ:    return {63'd0, irq};
      SEL_DMEMWE: return {63'd0, dmem_we};
      SEL_ENCDEC: return {63'd0, des_encdec};
      default:    return 64'hX;
    endcase
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        logic [63:0] e;
        logic [63:0] o;
        int          s;
        string       n;
        e = exp_q.pop_front();
        s = sel_q.pop_front();
        n = name_q.pop_front();
        o = observe(s);
        checks++;
        if (o === e) passed++;
        else $display("FAIL %s: got %h expected %h", n, o, e);
      end
    end
  end

  initial begin
    checks = 0;
    passed = 0;
    errors = 0;
    reset_n = 1'b0;
    memwrite = 1'b0;
    addr = 32'd0;
    writedata = 32'd0;
    dmem_rdata = DMEM_WORD;
    des_done = 1'b0;
    des_result = 64'd0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state
    rd(A_UK, 32'd0, "reset_uk");
    expect_sig(SEL_START, 64'd0, "reset_start");
    expect_sig(SEL_IRQ, 64'd0, "reset_irq");
    rd(A_STAT, 32'd0, "reset_status");
    expect_sig(SEL_KEY, 64'd0, "reset_key");

    // Register access
    wr(A_UK, 32'h0123_4567);
    wr(A_LK, 32'h89AB_CDEF);
    rd(A_UK, 32'h0123_4567, "rd_uk");
    expect_sig(SEL_KEY, 64'h0123_4567_89AB_CDEF, "des_key");
    rd(A_LK, 32'h89AB_CDEF, "rd_lk");
    wr(A_UD, 32'h1111_2222);
    wr(A_LD, 32'h3333_4444);
    rd(A_UD, 32'h1111_2222, "rd_ud");
    expect_sig(SEL_DATA, 64'h1111_2222_3333_4444, "des_data");

    // Start: one-cycle pulse, BUSY visible
    wr(A_CTRL, 32'h3);
    rd(A_STAT, 32'h1, "status_start");
    expect_sig(SEL_START, 64'd1, "start_pulse_hi");
    rd(A_STAT, 32'h1, "status_wait");
    expect_sig(SEL_START, 64'd0, "start_pulse_lo");
    expect_sig(SEL_ENCDEC, 64'd1, "encdec_enc");
    rd(A_CTRL, 32'h2, "ctrl_readback");

    // Overrun while busy
    wr(A_UD, 32'hFFFF_FFFF);
    rd(A_UD, 32'h1111_2222, "overrun_ud_kept");
    expect_sig(SEL_DATA, 64'h1111_2222_3333_4444, "overrun_data_stable");
    rd(A_STAT, 32'h5, "overrun_set");
    wr(A_STAT, 32'h4);
    rd(A_STAT, 32'h1, "overrun_w1c");
    for (int i = 0; i < 9; i++) idle();

    // Completion
    step(1'b0, 32'h0000_0100, 32'd0, 1'b1, 64'h85E8_1354_0F0A_B405);
    rd(A_STAT, 32'h2, "status_done");
    expect_sig(SEL_IRQ, 64'd0, "irq_disabled");
    rd(A_RESHI, 32'h85E8_1354, "res_hi");
    rd(A_RESLO, 32'h0F0A_B405, "res_lo");
    wr(A_RESHI, 32'hDEAD_BEEF);
    rd(A_RESHI, 32'h85E8_1354, "res_hi_ro");

    // Pass-through to dmem
    wr(32'h0000_0040, 32'h7777_7777);
    expect_sig(SEL_DMEMWE, 64'd1, "dmem_we_outside");
    rd(32'h0000_0040, DMEM_WORD, "dmem_read");
    rd(A_UK, 32'h0123_4567, "uk_untouched");
    wr(A_LK, 32'h0000_0055);
    expect_sig(SEL_DMEMWE, 64'd0, "dmem_we_inside");
    rd(A_LK, 32'h0000_0055, "lk_new");

    // IRQ and same-cycle DONE set vs W1C
    wr(A_CTRL, 32'h5);
    rd(A_STAT, 32'h1, "done_cleared_on_start");
    idle();
    step(1'b1, A_STAT, 32'h2, 1'b1, 64'hA5A5_5A5A_0F0F_F0F0);
    rd(A_STAT, 32'h2, "done_set_wins");
    expect_sig(SEL_IRQ, 64'd1, "irq_on_done");
    expect_sig(SEL_ENCDEC, 64'd0, "encdec_dec");
    rd(A_RESLO, 32'h0F0F_F0F0, "res_lo_2");
    wr(A_STAT, 32'h2);
    rd(A_STAT, 32'h0, "done_w1c");
    expect_sig(SEL_IRQ, 64'd0, "irq_cleared");

    // des_done while idle is ignored
    step(1'b0, 32'h0000_0100, 32'd0, 1'b1, 64'h1234_5678_9ABC_DEF0);
    rd(A_STAT, 32'h0, "idle_done_status");
    rd(A_RESLO, 32'h0F0F_F0F0, "idle_done_res");

    // Reset during WAIT, then a late completion
    wr(A_CTRL, 32'h1);
    idle();
    idle();
    step(1'b0, A_STAT, 32'd0, 1'b0, 64'd0);
    reset_n = 1'b0;
    expect_sig(SEL_RD, 64'd0, "reset_mid_status");
    expect_sig(SEL_START, 64'd0, "reset_mid_start");
    expect_sig(SEL_KEY, 64'd0, "reset_mid_key");
    expect_sig(SEL_DATA, 64'd0, "reset_mid_data");
    @(posedge clk);
    #1 reset_n = 1'b1;
    step(1'b0, 32'h0000_0100, 32'd0, 1'b1, 64'hFFFF_0000_FFFF_0000);
    rd(A_STAT, 32'h0, "late_done_status");
    rd(A_RESHI, 32'h0, "late_done_res");

`ifdef DES_TIMEOUT_EN
    wr(A_CTRL, 32'h1);
    for (int i = 0; i < 70; i++) idle();
    rd(A_STAT, 32'h8, "timeout_status");
    rd(A_RESHI, 32'h0, "timeout_res_kept");
`endif

    idle();
    idle();

    // Final report
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard: %0d expectations never checked", exp_q.size());
      errors++;
    end
    if (checks < 12) begin
      $display("FAIL coverage: only %0d checks ran", checks);
      errors++;
    end
    if (passed != checks) begin
      $display("FAIL mismatches: %0d of %0d checks failed", checks - passed, checks);
      errors++;
    end
    $display("%0d/%0d checks passed", passed, checks);
    if (errors == 0) $display("PASS");
    else             $display("FAIL (%0d report errors)", errors);
    $finish;
  end

endmodule
